// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART arbiter types, timing constants and helpers
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } arb_state_t;

   localparam int DATA_W_DEF   = 8;
   localparam int CLK_HZ       = 50_000_000;
   localparam int BAUD         = 115200;
   localparam int BIT_CYCLES   = CLK_HZ / BAUD;
   localparam int FRAME_CYCLES = 10 * BIT_CYCLES;
   // Next power of two above one full frame, so the watchdog never trips on a healthy byte.
   localparam int TIMEOUT_DEF  = 2 ** $clog2(FRAME_CYCLES);

   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner search from a pointer
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW:0] w_c;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_c     = '0;
      for (int k = 0; k < N; k++) begin
         w_c = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_c >= (IW+1)'(N)) w_c = w_c - (IW+1)'(N);
         if (!o_any && i_req[w_c[IW-1:0]]) begin
            o_any                 = 1'b1;
            o_idx                 = w_c[IW-1:0];
            o_grant[w_c[IW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte scheduler sharing one uart_tx, with packet lock and watchdog
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      tx_en_o,
   output logic [DATA_W-1:0]         tx_data_o,
   input  logic                      tx_done_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o,
   output logic                      err_timeout_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   arb_state_t        r_state;
   logic [IW-1:0]     r_rr_ptr;
   logic [IW-1:0]     r_owner;
   logic              r_lock;
   logic [TW-1:0]     r_timer;
   logic [DATA_W-1:0] r_data;
   logic              r_tx_en;
   logic [NUM_REQ-1:0] r_grant;

   logic [NUM_REQ-1:0] w_pick_grant;
   logic [IW-1:0]      w_pick_idx;
   logic               w_pick_any;
   logic               w_own_valid;
   logic               w_timeout;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .i_req   (req_valid_i),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_own_valid = req_valid_i[r_owner];
   assign w_timeout   = (r_timer == TMAX);

   // A done pulse or a HOLD transfer on the limit cycle beats the watchdog.
   assign err_timeout_o = rst_n && w_timeout &&
                          (((r_state == ST_WAIT) && !tx_done_i) ||
                           ((r_state == ST_HOLD) && !w_own_valid));

   always_comb begin
      req_ready_o = '0;
      if (r_state == ST_IDLE)
         req_ready_o = w_pick_grant;
      else if (r_state == ST_HOLD)
         req_ready_o[r_owner] = w_own_valid;
   end

   assign tx_en_o   = r_tx_en;
   assign tx_data_o = r_data;
   assign grant_o   = r_grant;
   assign busy_o    = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_lock   <= 1'b0;
         r_timer  <= '0;
         r_data   <= '0;
         r_tx_en  <= 1'b0;
         r_grant  <= '0;
      end else begin
         r_tx_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_any) begin
                  r_data  <= req_data_i[w_pick_idx*DATA_W +: DATA_W];
                  r_owner <= w_pick_idx;
                  r_lock  <= ~req_last_i[w_pick_idx];
                  r_grant <= w_pick_grant;
                  r_tx_en <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_timer <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (tx_done_i) begin
                  if (r_lock) begin
                     r_timer <= '0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_rr_ptr <= IW'(rr_next(int'(r_owner), NUM_REQ));
                     r_grant  <= '0;
                     r_state  <= ST_IDLE;
                  end
               end else if (w_timeout) begin
                  r_lock   <= 1'b0;
                  r_rr_ptr <= IW'(rr_next(int'(r_owner), NUM_REQ));
                  r_grant  <= '0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_own_valid) begin
                  r_data  <= req_data_i[r_owner*DATA_W +: DATA_W];
                  r_lock  <= ~req_last_i[r_owner];
                  r_timer <= '0;
                  r_tx_en <= 1'b1;
                  r_state <= ST_START;
               end else if (w_timeout) begin
                  r_lock   <= 1'b0;
                  r_rr_ptr <= IW'(rr_next(int'(r_owner), NUM_REQ));
                  r_grant  <= '0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int TO    = 64;
   localparam int FRAME = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid_i = '0;
   logic [N*DW-1:0] req_data_i = '0;
   logic [N-1:0]  req_last_i = '0;
   logic [N-1:0]  req_ready_o;
   logic          tx_en_o;
   logic [DW-1:0] tx_data_o;
   logic [N-1:0]  grant_o;
   logic          busy_o;
   logic          err_timeout_o;
   logic          t_done = 1'b0;
   logic          m_done = 1'b0;
   logic          tx_done_w;

   int n_chk = 0;
   int n_fail = 0;
   int n_overlap = 0;
   int m_cnt = 0;
   bit m_enable = 1'b1;
   logic [N-1:0]  q_grant[$];
   logic [DW-1:0] q_data[$];

   assign tx_done_w = t_done | m_done;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_data_i    (req_data_i),
      .req_last_i    (req_last_i),
      .req_ready_o   (req_ready_o),
      .tx_en_o       (tx_en_o),
      .tx_data_o     (tx_data_o),
      .tx_done_i     (tx_done_w),
      .grant_o       (grant_o),
      .busy_o        (busy_o),
      .err_timeout_o (err_timeout_o)
   );

   // Stand-in for uart_tx: a fixed-length frame after each start pulse, then a done pulse.
   always @(negedge clk) begin
      m_done = 1'b0;
      if (!busy_o) m_cnt = 0;
      else if (m_cnt != 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) m_done = 1'b1;
      end
      if (tx_en_o) begin
         q_grant.push_back(grant_o);
         q_data.push_back(tx_data_o);
         if (m_cnt != 0) n_overlap++;
         if (m_enable) m_cnt = FRAME;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      req_valid_i = '0; req_last_i = '0; req_data_i = '0; t_done = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (!busy_o) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_chk++; if ({req_ready_o, tx_en_o, tx_data_o, grant_o, busy_o, err_timeout_o} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got %h want 0", {req_ready_o, tx_en_o, tx_data_o, grant_o, busy_o, err_timeout_o});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      @(negedge clk);
      req_valid_i = 4'b0001; req_data_i = 32'h0000_00CC; req_last_i = 4'b1111; #1;
      n_chk++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready_o); end
      @(negedge clk);
      req_valid_i = '0; #1;
      n_chk++; if (tx_en_o !== 1'b1) begin n_fail++; $display("FAIL single_en got %b want 1", tx_en_o); end
      n_chk++; if (tx_data_o !== 8'hCC) begin n_fail++; $display("FAIL single_data got %h want cc", tx_data_o); end
      n_chk++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b want 0001", grant_o); end
      @(negedge clk); #1;
      n_chk++; if (tx_en_o !== 1'b0) begin n_fail++; $display("FAIL single_en_pulse got %b want 0", tx_en_o); end
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (tx_done_w) begin ok = 1'b1; break; end
      end
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_done_wait got timeout want done"); end
      n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_done got %b want 1", busy_o); end
      @(negedge clk); #1;
      n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy_o); end
      n_chk++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL single_grant_idle got %b want 0000", grant_o); end
      n_chk++; if (tx_data_o !== 8'hCC) begin n_fail++; $display("FAIL single_data_held got %h want cc", tx_data_o); end
   endtask

   task automatic test_round_robin();
      bit ok;
      logic [N-1:0]  eg [5];
      logic [DW-1:0] ed [5];
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
      apply_reset();
      q_grant.delete(); q_data.delete(); n_overlap = 0;
      @(negedge clk);
      req_valid_i = 4'b1111; req_data_i = 32'hA3A2_A1A0; req_last_i = 4'b1111;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         if (q_grant.size() >= 5) begin ok = 1'b1; break; end
      end
      req_valid_i = '0;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_collect got %0d bytes want 5", q_grant.size()); end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_idle got busy want idle"); end
      n_chk++; if (q_grant.size() != 5) begin n_fail++; $display("FAIL rr_count got %0d want 5", q_grant.size()); end
      for (int k = 0; k < 5 && k < q_grant.size(); k++) begin
         n_chk++; if (q_grant[k] !== eg[k] || q_data[k] !== ed[k]) begin
            n_fail++; $display("FAIL rr_order[%0d] got %b/%h want %b/%h", k, q_grant[k], q_data[k], eg[k], ed[k]);
         end
      end
      n_chk++; if (n_overlap != 0) begin n_fail++; $display("FAIL rr_overlap got %0d want 0", n_overlap); end
   endtask

   task automatic test_lock();
      bit ok;
      int idx;
      logic [DW-1:0] b [3];
      logic [N-1:0]  eg [4];
      logic [DW-1:0] ed [4];
      b  = '{8'h11, 8'h22, 8'h33};
      eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      ed = '{8'h11, 8'h22, 8'h33, 8'h2E};
      q_grant.delete(); q_data.delete();
      idx = 0; ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         req_valid_i[2] = 1'b1; req_data_i[23:16] = 8'h2E; req_last_i[2] = 1'b1;
         req_valid_i[1] = (idx < 3);
         req_data_i[15:8] = (idx < 3) ? b[idx] : 8'h00;
         req_last_i[1] = (idx == 2);
         #1;
         if (q_grant.size() >= 4) begin ok = 1'b1; break; end
         if (req_ready_o[1] && req_valid_i[1]) idx++;
      end
      req_valid_i = '0;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL lock_collect got %0d bytes want 4", q_grant.size()); end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL lock_idle got busy want idle"); end
      for (int k = 0; k < 4 && k < q_grant.size(); k++) begin
         n_chk++; if (q_grant[k] !== eg[k] || q_data[k] !== ed[k]) begin
            n_fail++; $display("FAIL lock_order[%0d] got %b/%h want %b/%h", k, q_grant[k], q_data[k], eg[k], ed[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int cnt;
      bit ok;
      m_enable = 1'b0;
      @(negedge clk);
      req_data_i = 32'h5300_0050; req_last_i = 4'b1111; req_valid_i = 4'b1001; #1;
      n_chk++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL to_ready got %b want 1000", req_ready_o); end
      @(negedge clk);
      req_valid_i = 4'b0001; #1;
      n_chk++; if (tx_en_o !== 1'b1 || grant_o !== 4'b1000) begin
         n_fail++; $display("FAIL to_start got en=%b grant=%b want 1/1000", tx_en_o, grant_o);
      end
      cnt = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk); #1;
         if (err_timeout_o) begin cnt = i; break; end
      end
      n_chk++; if (cnt != TO) begin n_fail++; $display("FAIL to_latency got %0d want %0d", cnt, TO); end
      @(negedge clk); #1;
      n_chk++; if (err_timeout_o !== 1'b0 || busy_o !== 1'b0 || grant_o !== 4'b0000) begin
         n_fail++; $display("FAIL to_abort got err=%b busy=%b grant=%b want 0/0/0000", err_timeout_o, busy_o, grant_o);
      end
      n_chk++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL to_next_ready got %b want 0001", req_ready_o); end
      @(negedge clk);
      req_valid_i = '0; #1;
      n_chk++; if (tx_en_o !== 1'b1 || grant_o !== 4'b0001 || tx_data_o !== 8'h50) begin
         n_fail++; $display("FAIL to_next_start got en=%b grant=%b data=%h want 1/0001/50", tx_en_o, grant_o, tx_data_o);
      end
      for (int i = 0; i < TO - 1; i++) @(negedge clk);
      @(negedge clk);
      t_done = 1'b1; #1;
      n_chk++; if (err_timeout_o !== 1'b0) begin n_fail++; $display("FAIL coincide_err got %b want 0", err_timeout_o); end
      @(negedge clk);
      t_done = 1'b0; #1;
      n_chk++; if (busy_o !== 1'b0 || err_timeout_o !== 1'b0) begin
         n_fail++; $display("FAIL coincide_idle got busy=%b err=%b want 0/0", busy_o, err_timeout_o);
      end
      @(negedge clk);
      t_done = 1'b1;
      @(negedge clk);
      t_done = 1'b0; #1;
      n_chk++; if (busy_o !== 1'b0 || tx_en_o !== 1'b0 || grant_o !== 4'b0000) begin
         n_fail++; $display("FAIL stray_done got busy=%b en=%b grant=%b want 0/0/0000", busy_o, tx_en_o, grant_o);
      end
      m_enable = 1'b1;
      @(negedge clk);
      req_data_i = 32'h7100_6100; req_valid_i = 4'b1010; #1;
      n_chk++; if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL stray_ptr got %b want 0010", req_ready_o); end
      @(negedge clk);
      req_valid_i = '0;
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL stray_idle got busy want idle"); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit err_seen;
      err_seen = 1'b0;
      @(negedge clk);
      req_data_i = 32'h0077_0000; req_last_i = 4'b1111; req_valid_i = 4'b0100; #1;
      n_chk++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_ready got %b want 0100", req_ready_o); end
      @(negedge clk);
      req_valid_i = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (err_timeout_o) err_seen = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0; #1;
      if (err_timeout_o) err_seen = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; #1;
      n_chk++; if ({req_ready_o, tx_en_o, tx_data_o, grant_o, busy_o, err_timeout_o} !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs got %h want 0", {req_ready_o, tx_en_o, tx_data_o, grant_o, busy_o, err_timeout_o});
      end
      @(negedge clk);
      req_data_i = 32'h9300_0090; req_valid_i = 4'b1001; #1;
      n_chk++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_ptr got %b want 0001", req_ready_o); end
      @(negedge clk);
      req_valid_i = '0; #1;
      n_chk++; if (tx_en_o !== 1'b1 || tx_data_o !== 8'h90) begin
         n_fail++; $display("FAIL rst_mid_restart got en=%b data=%h want 1/90", tx_en_o, tx_data_o);
      end
      wait_idle(ok);
      n_chk++; if (!ok || err_seen) begin n_fail++; $display("FAIL rst_mid_clean got idle=%b err=%b want 1/0", ok, err_seen); end
   endtask

   initial begin
      apply_reset();
      test_reset();
      apply_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got hang want completion");
      $fatal(1);
   end

endmodule
